// File: rtl/alu_pkg.sv
// Shared opcode constants, entry types and decode helpers for the ALU issue stage.
package alu_pkg;

   localparam int ALU_DATA_W = 16;

   localparam logic [2:0] NO_OPERATION = 3'b000;
   localparam logic [2:0] MUL          = 3'b001;
   localparam logic [2:0] ADD          = 3'b010;
   localparam logic [2:0] SUB          = 3'b011;
   localparam logic [2:0] DIV          = 3'b100;

   typedef struct packed {
      logic [2:0]            op;
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
   } req_t;

   typedef struct packed {
      logic [ALU_DATA_W-1:0] data;
      logic                  zero;
      logic                  err;
   } rsp_t;

   // How a slot's result is formed once it reaches the capture stage.
   typedef enum logic [1:0] {TAG_OK, TAG_DIV0, TAG_ILL} tag_e;

   function automatic logic is_illegal_op(input logic [2:0] op);
      return op > DIV;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; head entry is visible on rdata.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is left unreset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage in front of the ALU: queues requests, issues one per cycle under a
// response-buffer credit limit, and captures results in request order.
module alu_op_issue
   import alu_pkg::*;
#(
   parameter int DATA_W    = ALU_DATA_W,
   parameter int REQ_DEPTH = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [2:0]        alu_control,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zflag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic              busy
);
   localparam int QCW = $clog2(REQ_DEPTH) + 1;
   localparam int RCW = $clog2(RSP_DEPTH) + 1;

   req_t              req_wdata, req_head;
   rsp_t              rsp_wdata, rsp_head;
   logic              req_full, req_empty, rsp_empty, rsp_full_unused;
   logic [QCW-1:0]    req_count_unused;
   logic [RCW-1:0]    rsp_count;
   logic              issue;
   logic [1:0]        inflight;
   logic [RCW:0]      credit_used;

   logic [DATA_W-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
   logic [2:0]        alu_control_q, alu_control_d;
   logic              s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
   tag_e              s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;

   assign req_ready = !req_full;
   assign req_wdata = '{op: req_op, a: req_a, b: req_b};

   sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_valid && req_ready),
      .wdata (req_wdata),
      .pop   (issue),
      .rdata (req_head),
      .full  (req_full),
      .empty (req_empty),
      .count (req_count_unused)
   );

   // A slot is only issued if the response buffer is sure to have room for it.
   assign inflight    = {1'b0, s1_vld_q} + {1'b0, s2_vld_q};
   assign credit_used = {1'b0, rsp_count} + {{(RCW-1){1'b0}}, inflight};
   assign issue       = !req_empty && (credit_used < (RCW+1)'(RSP_DEPTH));

   always_comb begin
      alu_in1_d     = alu_in1_q;
      alu_in2_d     = alu_in2_q;
      alu_control_d = NO_OPERATION;
      s1_vld_d      = issue;
      s1_tag_d      = TAG_OK;
      if (issue) begin
         alu_in1_d = req_head.a;
         alu_in2_d = req_head.b;
         if (is_illegal_op(req_head.op))
            s1_tag_d = TAG_ILL;
         else if (req_head.op == DIV && req_head.b == '0)
            s1_tag_d = TAG_DIV0;
         else
            alu_control_d = req_head.op;
      end
      s2_vld_d = s1_vld_q;
      s2_tag_d = s1_tag_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_in1_q     <= '0;
         alu_in2_q     <= '0;
         alu_control_q <= NO_OPERATION;
         s1_vld_q      <= 1'b0;
         s2_vld_q      <= 1'b0;
         s1_tag_q      <= TAG_OK;
         s2_tag_q      <= TAG_OK;
      end else begin
         alu_in1_q     <= alu_in1_d;
         alu_in2_q     <= alu_in2_d;
         alu_control_q <= alu_control_d;
         s1_vld_q      <= s1_vld_d;
         s2_vld_q      <= s2_vld_d;
         s1_tag_q      <= s1_tag_d;
         s2_tag_q      <= s2_tag_d;
      end
   end

   // Suppressed slots never reached the ALU, so their result is synthesized here.
   always_comb begin
      rsp_wdata = '{data: alu_out, zero: alu_zflag, err: 1'b0};
      case (s2_tag_q)
         TAG_DIV0: rsp_wdata = '{data: '1, zero: 1'b0, err: 1'b1};
         TAG_ILL:  rsp_wdata = '{data: '0, zero: 1'b0, err: 1'b1};
         default:  ;
      endcase
   end

   sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_q (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s2_vld_q),
      .wdata (rsp_wdata),
      .pop   (rsp_valid && rsp_ready),
      .rdata (rsp_head),
      .full  (rsp_full_unused),
      .empty (rsp_empty),
      .count (rsp_count)
   );

   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_control = alu_control_q;
   assign rsp_valid   = !rsp_empty;
   assign rsp_data    = rsp_valid ? rsp_head.data : '0;
   assign rsp_zero    = rsp_valid && rsp_head.zero;
   assign rsp_err     = rsp_valid && rsp_head.err;
   assign busy        = !req_empty || (inflight != 2'd0) || (rsp_count != '0);

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Upstream stage of the matrix-multiplier ALU. Buffers operation requests (opcode plus two operands) from the controller in a small queue and issues at most one per cycle to the ALU.
- Tracks the ALU's one-cycle latency and captures each ALU result into a response buffer. Results leave over a valid/ready interface, in request order.
- Drives NO_OPERATION to the ALU whenever nothing is issued.

Parameters:
- DATA_W, 16, operand/result width (matches ALU datapath).
- REQ_DEPTH, 4, request queue entries (power of 2, >=2).
- RSP_DEPTH, 4, response buffer entries (power of 2, >=2); also the issue credit limit.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request queue can accept; equals !req_full.
- req_op  in  3  opcode: 000 NOP, 001 MUL, 010 ADD, 011 SUB, 100 DIV, 101-111 illegal.
- req_a  in  DATA_W  first operand (ALU in1).
- req_b  in  DATA_W  second operand (ALU in2).
- alu_in1  out  DATA_W  registered operand to ALU.
- alu_in2  out  DATA_W  registered operand to ALU.
- alu_control  out  3  registered ALU opcode.
- alu_out  in  DATA_W  ALU result, valid the cycle after the ALU samples.
- alu_zflag  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  result.
- rsp_zero  out  1  result-is-zero.
- rsp_err  out  1  illegal opcode or divide-by-zero.
- busy  out  1  any op queued, in flight, or unread.

Behaviour:
- Reset (async, rst_n=0):
  - Queues empty, pointers 0, in-flight tracking cleared.
  - alu_in1 = alu_in2 = 0, alu_control = 000.
  - rsp_valid = 0, rsp_data = 0, rsp_zero = 0, rsp_err = 0, busy = 0.
  - req_ready = 1 once reset is released.
- Request accept: occurs on a posedge with req_valid && req_ready. req_ready depends only on queue state; when the queue is full, req_ready = 0 even if a pop happens in the same cycle.
- Issue condition: queue non-empty && credits > 0, where credits = RSP_DEPTH - rsp_count - inflight.
- Issue action, at posedge I: pop the head and load alu_in1/alu_in2/alu_control. Set stage flag s1 with op/err tags.
- No issue: alu_control = 000; alu_in1/alu_in2 hold their values.
- Pipeline timing:
  - The ALU samples at posedge I+1; s1 moves to s2.
  - At posedge I+2, alu_out/alu_zflag are pushed into the response buffer.
  - Inflight counts s1+s2, max 2.
  - Minimum latency: accept at edge E, rsp_valid high after edge E+3.
  - Full throughput (one response per cycle) is sustained while rsp_ready = 1.
- Divide-by-zero (DIV with req_b = 0):
  - alu_control is forced to 000 for that slot.
  - Captured rsp_data = all-ones, rsp_err = 1, rsp_zero = 0.
- Illegal opcode (101-111):
  - alu_control is forced to 000.
  - rsp_data = 0, rsp_err = 1, rsp_zero = 0.
- NOP request: issued as 000, still produces a response. rsp_data = alu_out (the held value), rsp_zero = alu_zflag, rsp_err = 0.
- Arithmetic (performed by the ALU, documented for checking):
  - MUL truncated to the low DATA_W bits.
  - ADD/SUB modulo 2^DATA_W.
  - DIV is an unsigned quotient.
- Response buffer: FIFO; the head drives rsp_*. A pop occurs on rsp_valid && rsp_ready. Push and pop in the same cycle are allowed; the credit check guarantees the buffer never overflows.
- Ordering: responses appear in strict request order.
- busy = !req_empty || inflight != 0 || rsp_count != 0.
- Reset mid-operation: in-flight and buffered ops are discarded. No response is produced after release for pre-reset requests. The ALU itself is unreset, and its stale output is ignored because nothing is in flight.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W default.
  - Opcode constants NO_OPERATION/MUL/ADD/SUB/DIV.
  - Illegal-opcode decode function.
  - A typedef for the request entry {op, a, b} and the response entry {data, zero, err}.
- One sub-module, sync_fifo (params WIDTH, DEPTH; async active-low reset; push/pop/full/empty/count), instantiated twice: request queue and response buffer.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs at reset values immediately; after release, req_ready=1, busy=0, alu_control=000.
2. Single ADD a=5 b=7, rsp_ready=1 -> alu_control=010 one edge after accept; rsp_valid after 3rd edge with rsp_data=12, rsp_zero=0, rsp_err=0.
3. Back-to-back, rsp_ready=1:
   - Stimulus: MUL 300*300, SUB 9-9, DIV 100/7.
   - Required: responses on consecutive cycles: 24464, 0 (rsp_zero=1), 14, in order.
4. Backpressure: rsp_ready=0, offer 10 ADDs -> exactly 8 accepted (4 buffered responses, 4 queued); req_ready=0 thereafter. Raise rsp_ready -> 10 results drain in order; busy falls after the last.
5. Errors:
   - DIV a=10 b=0 -> alu_control stays 000 in its slot; rsp_data=FFFF, rsp_err=1.
   - op=111 -> rsp_data=0, rsp_err=1.
   - Following ADD 1+1 -> 2 with rsp_err=0.
6. Reset mid-operation: 3 ops in flight/buffered, pulse rst_n low -> rsp_valid=0 at once; after release, no response appears for 10 cycles with no new requests.
